// File: rtl/pa_pkg.sv
// Shared definitions for the PA pipeline: RISC-V major opcodes and the
// write-back request carried out of the MEM stage.
package pa_pkg;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OPC_LOAD  = 7'b0000011;
    localparam opcode_t OPC_STORE = 7'b0100011;
    localparam opcode_t OPC_OP    = 7'b0110011;
    localparam opcode_t OPC_OPIMM = 7'b0010011;
    localparam opcode_t OPC_LUI   = 7'b0110111;
    localparam opcode_t OPC_AUIPC = 7'b0010111;
    localparam opcode_t OPC_JAL   = 7'b1101111;
    localparam opcode_t OPC_JALR  = 7'b1100111;

    // Write-back request toward the register file.
    typedef struct packed {
        logic       wb;
        logic [4:0] dst;
    } wb_req_t;

    // Instructions whose execute result goes straight to write-back.
    function automatic logic is_passthru(input opcode_t op);
        return (op == OPC_OP)    || (op == OPC_OPIMM) || (op == OPC_LUI) ||
               (op == OPC_AUIPC) || (op == OPC_JAL)   || (op == OPC_JALR);
    endfunction

endpackage

// File: rtl/memory_ram.sv
// Single-port synchronous data RAM, word addressed, registered read.
module memory_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    // Contents are not touched by reset; the zero initial value only gives
    // simulation a defined starting image.
    logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

    // Write port: one word per edge when the stage commits a store.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    // Read port: holds its last word while the stage is stalled.
    always_ff @(posedge clk) begin
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/memory.sv
// MEM stage: word load/store against the data RAM, passthrough of the
// execute result, and the registered write-back request.
module memory
    import pa_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [4:0]        dst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [6:0]        memOP,
    output logic              WB,
    output logic [4:0]        dstout,
    output logic [DATA_W-1:0] data_out
);

    logic              is_load;
    logic              is_store;
    logic              ram_we;
    wb_req_t           wb_d;
    wb_req_t           wb_q;
    logic              sel_load;
    logic [DATA_W-1:0] pass_q;
    logic [DATA_W-1:0] ram_rdata;

    // Opcode decode; x0 is never a write-back target.
    always_comb begin
        is_load  = (memOP == OPC_LOAD);
        is_store = (memOP == OPC_STORE);
        ram_we   = is_store && enable && !rst;
        wb_d.wb  = (is_load || is_passthru(memOP)) && (dst != 5'd0);
        wb_d.dst = dst;
    end

    memory_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (enable),
        .addr  (MemAddr),
        .wdata (data_in),
        .rdata (ram_rdata)
    );

    // Stage register: reset clears the in-flight request, stall holds it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q     <= '0;
            pass_q   <= '0;
            sel_load <= 1'b0;
        end else if (enable) begin
            wb_q     <= wb_d;
            pass_q   <= data_in;
            sel_load <= is_load;
        end
    end

    // The RAM read is already registered, so the load path picks it up
    // directly behind the stage register.
    assign WB       = wb_q.wb;
    assign dstout   = wb_q.dst;
    assign data_out = sel_load ? ram_rdata : pass_q;

endmodule

// File: tb/tb_memory.sv
// Directed-vector bench for the MEM stage with a queue-based scoreboard.
module tb_memory;
    import pa_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [9:0]  MemAddr = '0;
    logic [4:0]  dst = '0;
    logic [31:0] data_in = '0;
    logic [6:0]  memOP = '0;
    logic        WB;
    logic [4:0]  dstout;
    logic [31:0] data_out;

    typedef struct {
        logic        wb;
        logic [4:0]  dst;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    logic issue = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    memory #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .MemAddr  (MemAddr),
        .dst      (dst),
        .data_in  (data_in),
        .memOP    (memOP),
        .WB       (WB),
        .dstout   (dstout),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Drive one vector for one edge and queue its expected result.
    task automatic apply(input logic r, input logic en, input logic [6:0] op,
                         input logic [9:0] a, input logic [4:0] d,
                         input logic [31:0] din, input logic ewb,
                         input logic [4:0] edst, input logic [31:0] edata,
                         input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; enable = en; memOP = op; MemAddr = a; dst = d; data_in = din;
        e.wb = ewb; e.dst = edst; e.data = edata; e.name = nm;
        exp_q.push_back(e);
        issue = 1'b1;
    endtask

    // Monitor: every edge that consumed a vector is checked 1 time unit later.
    initial begin
        logic launched;
        exp_t e;
        forever begin
            @(posedge clk);
            launched = issue;
            if (launched) begin
                #1;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_underflow: output seen with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    if (WB !== e.wb || dstout !== e.dst || data_out !== e.data) begin
                        n_bad++;
                        $display("FAIL %s: got WB=%b dstout=%0d data_out=%h, want WB=%b dstout=%0d data_out=%h",
                                 e.name, WB, dstout, data_out, e.wb, e.dst, e.data);
                    end
                end
            end
        end
    end

    initial begin
        // Reset with random inputs, including a store that must be dropped.
        apply(1, 1, OPC_STORE, 10'd9, 5'($urandom_range(1, 31)), $urandom, 0, 0, 0, "reset_0");
        apply(1, $urandom_range(0, 1) == 1, OPC_STORE, 10'd9, 5'($urandom_range(1, 31)), $urandom,
              0, 0, 0, "reset_1");
        // Store then load back.
        apply(0, 1, OPC_STORE, 10'd5, 5'd3, 32'hDEADBEEF, 0, 3, 32'hDEADBEEF, "store_a5");
        apply(0, 1, OPC_LOAD, 10'd5, 5'd7, 32'h0, 1, 7, 32'hDEADBEEF, "load_a5");
        // Passthrough and x0 suppression.
        apply(0, 1, OPC_OP, 10'd0, 5'd10, 32'h12345678, 1, 10, 32'h12345678, "op_pass");
        apply(0, 1, OPC_OPIMM, 10'd0, 5'd0, 32'h1, 0, 0, 32'h1, "opimm_x0");
        // Stall: outputs hold, stalled store never reaches the RAM.
        apply(0, 0, OPC_STORE, 10'd9, 5'd12, 32'hAAAA5555, 0, 0, 32'h1, "stall_store");
        apply(0, 0, OPC_LOAD, 10'd5, 5'd4, 32'h0, 0, 0, 32'h1, "stall_load");
        apply(0, 1, OPC_LOAD, 10'd9, 5'd9, 32'h0, 1, 9, 32'h0, "load_a9_after_stall");
        // Top address.
        apply(0, 1, OPC_STORE, 10'd1023, 5'd2, 32'hCAFEF00D, 0, 2, 32'hCAFEF00D, "store_a1023");
        apply(0, 1, OPC_LOAD, 10'd1023, 5'd31, 32'h0, 1, 31, 32'hCAFEF00D, "load_a1023");
        // Bubble and the other opcode classes.
        apply(0, 1, 7'd0, 10'd3, 5'd6, 32'h55, 0, 6, 32'h55, "bubble");
        apply(0, 1, OPC_LUI, 10'd0, 5'd8, 32'h000AB000, 1, 8, 32'h000AB000, "lui_pass");
        apply(0, 1, OPC_JAL, 10'd0, 5'd1, 32'h4, 1, 1, 32'h4, "jal_pass");
        apply(0, 1, OPC_BRANCH, 10'd5, 5'd5, 32'h77, 0, 5, 32'h77, "branch_nowb");
        apply(0, 1, OPC_LOAD, 10'd0, 5'd0, 32'h0, 0, 0, 32'h0, "load_x0");
        // Mid-stream reset drops the store and the write-back; RAM survives.
        apply(1, 1, OPC_STORE, 10'd0, 5'd4, 32'h0BADF00D, 0, 0, 32'h0, "reset_store");
        apply(0, 1, OPC_LOAD, 10'd0, 5'd11, 32'h0, 1, 11, 32'h0, "load_a0_after_reset");
        apply(0, 1, OPC_AUIPC, 10'd0, 5'd13, 32'h1000, 1, 13, 32'h1000, "auipc_pass");
        apply(0, 1, OPC_JALR, 10'd0, 5'd14, 32'h8, 1, 14, 32'h8, "jalr_pass");
        apply(0, 1, OPC_LOAD, 10'd5, 5'd21, 32'h0, 1, 21, 32'hDEADBEEF, "load_a5_after_reset");
        @(negedge clk);
        issue = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
